// File: rtl/sprite_pkg.sv
// Shared types for the sprite draw command queue.
// sprite_cmd_t is the 48-bit command word stored per queue entry:
//   id (8) | x (16, signed) | y (16, signed) | scale (8)
package sprite_pkg;
  localparam int SPRITE_ID_W    = 8;
  localparam int SPRITE_COORD_W = 16;
  localparam int SPRITE_SCALE_W = 8;

  typedef struct packed {
    logic        [SPRITE_ID_W-1:0]    id;
    logic signed [SPRITE_COORD_W-1:0] x;
    logic signed [SPRITE_COORD_W-1:0] y;
    logic        [SPRITE_SCALE_W-1:0] scale;
  } sprite_cmd_t;

  localparam int SPRITE_CMD_W = $bits(sprite_cmd_t);
endpackage

// File: rtl/sprite_queue_ram.sv
// Simple dual-port command RAM, DEPTH x sprite_cmd_t.
// One write port, one synchronous read port (1-cycle latency). The read data
// register doubles as the queue's head register, so it holds its value when
// no read is issued and clears on clr_i.
// Ports:
//   clk_i            clock
//   clr_i            clears the read data register (reset or flush)
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i     read request, data appears on rdata_o next cycle
//   rdata_o          registered read data
module sprite_queue_ram
  import sprite_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  sprite_cmd_t   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output sprite_cmd_t   rdata_o
);
  sprite_cmd_t mem_q [DEPTH];
  sprite_cmd_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (clr_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sprite_draw_queue.sv
// Sprite draw command FIFO with batch commit and first-word-fall-through read.
// The producer enqueues commands; only entries covered by a commit become
// visible to the consumer. The head entry lives in the RAM read register.
// Optional debug counters are enabled by defining SPRITE_QUEUE_STATS_EN.
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   enqueue, in_sprite_*    write one command
//   commit                  publish everything written so far (incl. this cycle)
//   flush                   discard all entries (wins over everything else)
//   is_full, overflow       registered full flag, sticky drop flag
//   dequeue, is_empty       consumer pop / no valid head
//   sprite_*                head entry fields
//   committed_count         committed entries not yet popped, incl. head
//   dropped_count, high_water  (SPRITE_QUEUE_STATS_EN only) debug counters
module sprite_draw_queue
  import sprite_pkg::*;
#(
  parameter int DEPTH   = 256,
  localparam int PTR_W  = $clog2(DEPTH) + 1,
  localparam int AW     = PTR_W - 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enqueue,
  input  logic [SPRITE_ID_W-1:0]    in_sprite_id,
  input  logic [SPRITE_COORD_W-1:0] in_sprite_x,
  input  logic [SPRITE_COORD_W-1:0] in_sprite_y,
  input  logic [SPRITE_SCALE_W-1:0] in_sprite_scale,
  input  logic                      commit,
  input  logic                      flush,
  output logic                      is_full,
  output logic                      overflow,
  input  logic                      dequeue,
  output logic                      is_empty,
  output logic [SPRITE_ID_W-1:0]    sprite_id,
  output logic [SPRITE_COORD_W-1:0] sprite_x,
  output logic [SPRITE_COORD_W-1:0] sprite_y,
  output logic [SPRITE_SCALE_W-1:0] sprite_scale,
  output logic [PTR_W-1:0]          committed_count
`ifdef SPRITE_QUEUE_STATS_EN
  ,
  output logic [15:0]               dropped_count,
  output logic [PTR_W-1:0]          high_water
`endif
);
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             head_valid_q, head_valid_d;
  logic             is_full_q, is_full_d;
  logic             overflow_q, overflow_d;
  logic             wr_en, rd_en, drop;
  sprite_cmd_t      wr_cmd, head;

  assign wr_cmd.id    = in_sprite_id;
  assign wr_cmd.x     = in_sprite_x;
  assign wr_cmd.y     = in_sprite_y;
  assign wr_cmd.scale = in_sprite_scale;

  always_comb begin
    wr_en        = enqueue && !is_full_q;
    drop         = enqueue && is_full_q;
    // Fetch into an empty head, or refill the head on a pop (no bubble).
    rd_en        = (rd_ptr_q != commit_ptr_q) && (!head_valid_q || dequeue);
    wr_ptr_d     = wr_ptr_q + PTR_W'(wr_en);
    commit_ptr_d = commit ? wr_ptr_d : commit_ptr_q;
    rd_ptr_d     = rd_ptr_q + PTR_W'(rd_en);
    head_valid_d = rd_en || (head_valid_q && !dequeue);
    overflow_d   = overflow_q || drop;
    if (flush) begin
      wr_en        = 1'b0;
      rd_en        = 1'b0;
      drop         = 1'b0;
      wr_ptr_d     = '0;
      commit_ptr_d = '0;
      rd_ptr_d     = '0;
      head_valid_d = 1'b0;
      overflow_d   = 1'b0;
    end
    // Uncommitted entries count toward fullness.
    is_full_d = (wr_ptr_d - rd_ptr_d) == PTR_W'(DEPTH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      head_valid_q <= 1'b0;
      is_full_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_valid_q <= head_valid_d;
      is_full_q    <= is_full_d;
      overflow_q   <= overflow_d;
    end
  end

  sprite_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (clock),
    .clr_i   (reset || flush),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_cmd),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (head)
  );

  assign is_full         = is_full_q;
  assign overflow        = overflow_q;
  assign is_empty        = !head_valid_q;
  assign sprite_id       = head.id;
  assign sprite_x        = head.x;
  assign sprite_y        = head.y;
  assign sprite_scale    = head.scale;
  assign committed_count = (commit_ptr_q - rd_ptr_q) + PTR_W'(head_valid_q);

`ifdef SPRITE_QUEUE_STATS_EN
  logic [15:0]      dropped_q;
  logic [PTR_W-1:0] high_water_q, occ_d;

  assign occ_d = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      dropped_q    <= '0;
      high_water_q <= '0;
    end else begin
      if (drop && dropped_q != '1) dropped_q <= dropped_q + 16'd1;
      if (occ_d > high_water_q)     high_water_q <= occ_d;
    end
  end

  assign dropped_count = dropped_q;
  assign high_water    = high_water_q;
`endif
endmodule

// File: tb/tb_sprite_draw_queue.sv
module tb_sprite_draw_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 3;

  logic        clock = 1'b0;
  logic        reset, enqueue, commit, flush, dequeue;
  logic [7:0]  in_sprite_id, in_sprite_scale;
  logic [15:0] in_sprite_x, in_sprite_y;
  logic        is_full, overflow, is_empty;
  logic [7:0]  sprite_id, sprite_scale;
  logic [15:0] sprite_x, sprite_y;
  logic [PTR_W-1:0] committed_count;
`ifdef SPRITE_QUEUE_STATS_EN
  logic [15:0]      dropped_count;
  logic [PTR_W-1:0] high_water;
`endif

  sprite_draw_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .enqueue(enqueue),
    .in_sprite_id(in_sprite_id), .in_sprite_x(in_sprite_x),
    .in_sprite_y(in_sprite_y), .in_sprite_scale(in_sprite_scale),
    .commit(commit), .flush(flush), .is_full(is_full), .overflow(overflow),
    .dequeue(dequeue), .is_empty(is_empty), .sprite_id(sprite_id),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_scale(sprite_scale),
    .committed_count(committed_count)
`ifdef SPRITE_QUEUE_STATS_EN
    , .dropped_count(dropped_count), .high_water(high_water)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [47:0] exp_q[$];
  logic [47:0] pend_q[$];
  logic [47:0] mon_e;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic publish();
    while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
  endtask

  // accept: hand-determined whether the queue has room for this entry
  task automatic enq(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                     input logic [7:0] sc, input bit accept, input bit com);
    enqueue = 1'b1; commit = com;
    in_sprite_id = id; in_sprite_x = x; in_sprite_y = y; in_sprite_scale = sc;
    if (accept) pend_q.push_back({id, x, y, sc});
    if (com) publish();
    cyc();
    enqueue = 1'b0; commit = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1; publish(); cyc(); commit = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (is_empty == 1'b0 && n < max) begin
      dequeue = 1'b1; cyc(); n++;
    end
    dequeue = 1'b0;
    chk("drain_done_empty", is_empty, 1);
  endtask

  task automatic wait_vis(input int max);
    int n = 0;
    while (is_empty == 1'b1 && n < max) begin cyc(); n++; end
    chk("visible_within_bound", is_empty, 0);
  endtask

  // Scoreboard monitor: every effective pop must match the oldest committed entry.
  always @(negedge clock) begin
    if (!reset && !flush && dequeue && !is_empty) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got id=%0h want no entry", sprite_id);
      end else begin
        mon_e = exp_q.pop_front();
        if ({sprite_id, sprite_x, sprite_y, sprite_scale} !== mon_e) begin
          bad++;
          $display("FAIL pop_data: got=%0h want=%0h",
                   {sprite_id, sprite_x, sprite_y, sprite_scale}, mon_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enqueue = 0; commit = 0; flush = 0; dequeue = 0;
    in_sprite_id = 0; in_sprite_x = 0; in_sprite_y = 0; in_sprite_scale = 0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_empty", is_empty, 1);
    chk("rst_full", is_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", committed_count, 0);
    chk("rst_head", {sprite_id, sprite_x, sprite_y, sprite_scale}, 0);

    // Uncommitted entries stay hidden; visible exactly 2 cycles after commit.
    enq(8'd10, 16'hFFF6, 16'h0020, 8'h01, 1, 0);
    enq(8'd11, 16'h7FFF, 16'h8000, 8'h02, 1, 0);
    enq(8'd12, 16'h0001, 16'hFFFF, 8'hFF, 1, 0);
    chk("uncommitted_empty", is_empty, 1);
    chk("uncommitted_count", committed_count, 0);
    do_commit();
    chk("commit_n1_empty", is_empty, 1);
    cyc();
    chk("commit_n2_empty", is_empty, 0);
    chk("commit_n2_count", committed_count, 3);
    chk("commit_n2_head", sprite_id, 8'd10);
    drain(10);
    chk("t1_count_zero", committed_count, 0);

    // Back-to-back pops with dequeue held high.
    for (int i = 1; i <= 4; i++) enq(8'(i), 16'(i * 16'h100), 16'(-i), 8'(i), 1, 0);
    chk("four_full", is_full, 1);
    do_commit();
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("t2_nonempty", is_empty, 0);
      dequeue = 1'b1; cyc();
    end
    dequeue = 1'b0;
    chk("t2_empty", is_empty, 1);
    chk("t2_count", committed_count, 0);

    // Full, overflow, and enqueue+dequeue while full.
    for (int i = 0; i < 4; i++) enq(8'(20 + i), 16'h1234, 16'h5678, 8'h10, 1, 0);
    chk("t3_full", is_full, 1);
    chk("t3_no_overflow", overflow, 0);
    enq(8'd99, 16'h0, 16'h0, 8'h0, 0, 0);
    chk("t3_overflow", overflow, 1);
    chk("t3_full_after_drop", is_full, 1);
    do_commit();
    chk("t3_full_after_commit", is_full, 1);
    cyc();
    chk("t3_full_after_fetch", is_full, 0);
    chk("t3_head20", sprite_id, 8'd20);
    enq(8'd24, 16'hABCD, 16'h0042, 8'h24, 1, 0);
    chk("t3_full_again", is_full, 1);
    dequeue = 1'b1;
    enq(8'd98, 16'h0, 16'h0, 8'h0, 0, 0);
    dequeue = 1'b0;
    chk("t3_head21", sprite_id, 8'd21);
    chk("t3_not_full", is_full, 0);
    do_commit();
    drain(20);
    chk("t3_scoreboard_drained", exp_q.size(), 0);
    chk("t3_overflow_sticky", overflow, 1);

    // Enqueue with commit in the same cycle, then flush beats enqueue+commit.
    enq(8'd7, 16'hFF00, 16'h00FF, 8'h07, 1, 1);
    cyc();
    chk("t4_id7_visible", is_empty, 0);
    chk("t4_id7_head", sprite_id, 8'd7);
    drain(10);
    enq(8'd8, 16'h0008, 16'h0008, 8'h08, 1, 1);
    cyc();
    flush = 1'b1; dequeue = 1'b1; commit = 1'b1; enqueue = 1'b1; in_sprite_id = 8'd9;
    cyc();
    flush = 1'b0; dequeue = 1'b0; commit = 1'b0; enqueue = 1'b0;
    exp_q.delete(); pend_q.delete();
    chk("flush_empty", is_empty, 1);
    chk("flush_overflow", overflow, 0);
    chk("flush_full", is_full, 0);
    chk("flush_count", committed_count, 0);
    chk("flush_head", {sprite_id, sprite_x, sprite_y, sprite_scale}, 0);
    repeat (3) cyc();
    chk("flush_stays_empty", is_empty, 1);

    // Wrap-around: 30 entries through a 4-deep queue.
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++)
        enq(8'(100 + r * 3 + k), 16'(-(r * 3 + k)), 16'(r * 3 + k), 8'(r), 1, k == 2);
      wait_vis(6);
      drain(10);
      chk("wrap_count", committed_count, 0);
    end
    chk("wrap_scoreboard_drained", exp_q.size(), 0);

    // Dequeue while empty has no effect; head output holds last value.
    dequeue = 1'b1; cyc(); cyc(); dequeue = 1'b0;
    chk("empty_deq_empty", is_empty, 1);
    chk("empty_deq_count", committed_count, 0);
    chk("empty_deq_hold", sprite_id, 8'd129);
    chk("empty_deq_full", is_full, 0);

    // Reset in the middle of a drain.
    enq(8'd50, 16'h0050, 16'h0050, 8'h50, 1, 0);
    enq(8'd51, 16'h0051, 16'h0051, 8'h51, 1, 0);
    enq(8'd52, 16'h0052, 16'h0052, 8'h52, 1, 1);
    wait_vis(6);
    dequeue = 1'b1; cyc();
    reset = 1'b1; cyc();
    reset = 1'b0; dequeue = 1'b0;
    exp_q.delete(); pend_q.delete();
    chk("mid_rst_empty", is_empty, 1);
    chk("mid_rst_count", committed_count, 0);
    chk("mid_rst_head", {sprite_id, sprite_x, sprite_y, sprite_scale}, 0);
    chk("mid_rst_full", is_full, 0);
    chk("mid_rst_overflow", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
